stack_slider: RTL and testbench
===============================

# stack_slider

Parametrised moving-block position generator for the block-stacker game. Bounces the active block horizontally across the playfield at a level-dependent rate. Freezes the block on a player drop and hands the landed x to game logic. Advances one row up per successful placement. Drives x/y/colour into the VGA draw datapath and reports game over and win.

## Interface

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- X_MAX, 156, rightmost x; must be a multiple of STEP
- STEP, 4, pixels per horizontal move
- Y_START, 116, y of row 0
- ROW_H, 4, pixels per row
- ROWS, 30, rows to win (row ROWS-1 at y = Y_START - (ROWS-1)*ROW_H)
- LVL_W, 5, level counter width
- CNT_W, 4, prescaler width
- PERIOD_INIT, 8, ticks per move at level 0
- PERIOD_MIN, 2, lower bound on ticks per move

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  begin or restart a game (IDLE, DONE, WIN only)
- step_tick  in  1  one-cycle motion time base
- drop  in  1  player drop request
- drop_ack  in  1  game logic consumed drop_x
- drop_hit  in  1  qualifies drop_ack: 1 = placement ok
- colour_in  in  3  block colour
- colour_erase_enable  in  1  force black
- x  out  X_W  block x
- y  out  Y_W  block y
- dir  out  1  1 = moving right
- level  out  LVL_W  current row index
- drop_valid  out  1  drop_x valid, held until ack
- drop_x  out  X_W  x frozen at drop
- game_over  out  1  sticky miss flag
- win  out  1  sticky top-reached flag
- colour  out  3  combinational: 0 if colour_erase_enable else colour_in

## Operation

- States: IDLE, MOVE, HOLD, DONE, WIN.
- IDLE/DONE/WIN + start: next cycle MOVE. x=0, dir=1, y=Y_START, level=0, prescaler=0, game_over=0, win=0.
- MOVE: each step_tick increments prescaler. At prescaler==period-1 with step_tick: prescaler clears and x moves.
  - dir=1: x==X_MAX gives x=X_MAX-STEP, dir=0; otherwise x+=STEP.
  - dir=0: x==0 gives x=STEP, dir=1; otherwise x-=STEP.
- MOVE + drop: go to HOLD. drop_x=x, drop_valid=1. drop outranks a same-cycle move; x does not move.
- HOLD: step_tick and drop are ignored. drop_valid stays high until drop_ack.
- HOLD + drop_ack + drop_hit:
  - level==ROWS-1: WIN, win=1, y unchanged.
  - Otherwise MOVE: y-=ROW_H, level+=1, x=0, dir=1, prescaler=0.
- HOLD + drop_ack + !drop_hit: DONE, game_over=1.
- drop_valid clears on the ack cycle's next edge.
- start is ignored in MOVE/HOLD. drop_ack is ignored outside HOLD.
- Arithmetic is unsigned at declared widths. Configurations that could wrap are illegal.

## Timing

- Reset values: state=IDLE, x=0, y=Y_START, dir=1, level=0, drop_valid=0, drop_x=0, game_over=0, win=0, prescaler=0.
- Reset mid-game (any state) returns to these values on the next edge.
- Move latency: x updates on the edge after the qualifying step_tick cycle.
- drop sampled in MOVE gives drop_valid=1 on the next edge.
- Ack sampled gives updated y/level/state on the next edge.
- Back-to-back drop on the first MOVE cycle after a level-up is accepted.
- colour has zero latency.

## Configuration

- SLIDER_SPEEDUP_EN defined: period = max(PERIOD_MIN, PERIOD_INIT - level). The game speeds up one tick per row.
- Undefined: period = PERIOD_INIT at all levels. level is still counted and output.

## Test plan

- Reset low 2 cycles -> all outputs at reset values; start -> MOVE; 8 step_ticks -> x=4, dir=1.
- Run to x=156; next 8 ticks -> x=152, dir=0. Continue to x=0; next 8 ticks -> x=4, dir=1.
- At x=40, drop and a qualifying step_tick in the same cycle -> drop_valid=1, drop_x=40, x stays 40. 20 ticks with no ack -> unchanged.
- Ack with hit=1 -> y=112, level=1, x=0, drop_valid=0. With SPEEDUP_EN, x=4 after 7 ticks; without, after 8.
- Ack with hit=0 -> DONE, game_over=1. start -> MOVE, game_over=0, y=116.
- 30 consecutive hits -> WIN, win=1, y=0.
- colour_erase_enable=1 with colour_in=5 -> colour=0; when deasserted -> colour=5.
- Reset asserted in HOLD -> IDLE, drop_valid=0.

Source files
------------

// File: rtl/stack_slider_if.sv
// Handshake and draw bus between the block-stacker game logic and stack_slider.
interface stack_slider_if #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned LVL_W = 5
);
  logic             start;
  logic             step_tick;
  logic             drop;
  logic             drop_ack;
  logic             drop_hit;
  logic [2:0]       colour_in;
  logic             colour_erase_enable;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             dir;
  logic [LVL_W-1:0] level;
  logic             drop_valid;
  logic [X_W-1:0]   drop_x;
  logic             game_over;
  logic             win;
  logic [2:0]       colour;

  modport master (
    output start, step_tick, drop, drop_ack, drop_hit, colour_in, colour_erase_enable,
    input  x, y, dir, level, drop_valid, drop_x, game_over, win, colour
  );

  modport slave (
    input  start, step_tick, drop, drop_ack, drop_hit, colour_in, colour_erase_enable,
    output x, y, dir, level, drop_valid, drop_x, game_over, win, colour
  );
endinterface

// File: rtl/stack_slider.sv
// Moving-block position generator: bounces the block, freezes it on drop, climbs a row per hit.
// Optional SLIDER_SPEEDUP_EN: move period shrinks by one tick per level down to PERIOD_MIN.
module stack_slider #(
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter int unsigned X_MAX       = 156,
  parameter int unsigned STEP        = 4,
  parameter int unsigned Y_START     = 116,
  parameter int unsigned ROW_H       = 4,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned LVL_W       = 5,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERIOD_INIT = 8,
  parameter int unsigned PERIOD_MIN  = 2
) (
  input logic          clk,
  input logic          reset,
  stack_slider_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MOVE = 3'd1,
    S_HOLD = 3'd2,
    S_DONE = 3'd3,
    S_WIN  = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [X_W-1:0]   r_x, w_x_nxt;
  logic [Y_W-1:0]   r_y, w_y_nxt;
  logic             r_dir, w_dir_nxt;
  logic [LVL_W-1:0] r_level, w_level_nxt;
  logic [CNT_W-1:0] r_presc, w_presc_nxt;
  logic             r_drop_valid, w_drop_valid_nxt;
  logic [X_W-1:0]   r_drop_x, w_drop_x_nxt;
  logic             r_game_over, w_game_over_nxt;
  logic             r_win, w_win_nxt;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_period_m1;

`ifdef SLIDER_SPEEDUP_EN
  localparam int unsigned SPAN = PERIOD_INIT - PERIOD_MIN;
  always_comb begin
    if (32'(r_level) >= SPAN) w_period = CNT_W'(PERIOD_MIN);
    else                      w_period = CNT_W'(PERIOD_INIT - 32'(r_level));
  end
`else
  always_comb w_period = CNT_W'(PERIOD_INIT);
`endif

  assign w_period_m1 = w_period - CNT_W'(1);

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_x          <= '0;
      r_y          <= Y_W'(Y_START);
      r_dir        <= 1'b1;
      r_level      <= '0;
      r_presc      <= '0;
      r_drop_valid <= 1'b0;
      r_drop_x     <= '0;
      r_game_over  <= 1'b0;
      r_win        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_dir        <= w_dir_nxt;
      r_level      <= w_level_nxt;
      r_presc      <= w_presc_nxt;
      r_drop_valid <= w_drop_valid_nxt;
      r_drop_x     <= w_drop_x_nxt;
      r_game_over  <= w_game_over_nxt;
      r_win        <= w_win_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state_nxt      = r_state;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_dir_nxt        = r_dir;
    w_level_nxt      = r_level;
    w_presc_nxt      = r_presc;
    w_drop_valid_nxt = r_drop_valid;
    w_drop_x_nxt     = r_drop_x;
    w_game_over_nxt  = r_game_over;
    w_win_nxt        = r_win;

    case (r_state)
      S_IDLE, S_DONE, S_WIN: begin
        if (bus.start) begin
          w_state_nxt     = S_MOVE;
          w_x_nxt         = '0;
          w_dir_nxt       = 1'b1;
          w_y_nxt         = Y_W'(Y_START);
          w_level_nxt     = '0;
          w_presc_nxt     = '0;
          w_game_over_nxt = 1'b0;
          w_win_nxt       = 1'b0;
        end
      end

      S_MOVE: begin
        // A drop freezes the block even if a move was due this cycle
        if (bus.drop) begin
          w_state_nxt      = S_HOLD;
          w_drop_valid_nxt = 1'b1;
          w_drop_x_nxt     = r_x;
        end else if (bus.step_tick) begin
          if (r_presc == w_period_m1) begin
            w_presc_nxt = '0;
            if (r_dir) begin
              if (r_x == X_W'(X_MAX)) begin
                w_x_nxt   = X_W'(X_MAX - STEP);
                w_dir_nxt = 1'b0;
              end else begin
                w_x_nxt = r_x + X_W'(STEP);
              end
            end else begin
              if (r_x == '0) begin
                w_x_nxt   = X_W'(STEP);
                w_dir_nxt = 1'b1;
              end else begin
                w_x_nxt = r_x - X_W'(STEP);
              end
            end
          end else begin
            w_presc_nxt = r_presc + CNT_W'(1);
          end
        end
      end

      S_HOLD: begin
        if (bus.drop_ack) begin
          w_drop_valid_nxt = 1'b0;
          if (bus.drop_hit) begin
            if (r_level == LVL_W'(ROWS - 1)) begin
              w_state_nxt = S_WIN;
              w_win_nxt   = 1'b1;
            end else begin
              w_state_nxt = S_MOVE;
              w_y_nxt     = r_y - Y_W'(ROW_H);
              w_level_nxt = r_level + LVL_W'(1);
              w_x_nxt     = '0;
              w_dir_nxt   = 1'b1;
              w_presc_nxt = '0;
            end
          end else begin
            w_state_nxt     = S_DONE;
            w_game_over_nxt = 1'b1;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.x          = r_x;
  assign bus.y          = r_y;
  assign bus.dir        = r_dir;
  assign bus.level      = r_level;
  assign bus.drop_valid = r_drop_valid;
  assign bus.drop_x     = r_drop_x;
  assign bus.game_over  = r_game_over;
  assign bus.win        = r_win;
  assign bus.colour     = bus.colour_erase_enable ? 3'd0 : bus.colour_in;

endmodule

// File: tb/tb_stack_slider.sv
// Directed bench for stack_slider: bounce, drop/hold, level-up, miss, win, colour and reset.
module tb_stack_slider;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  stack_slider_if #(.X_W(8), .Y_W(7), .LVL_W(5)) bus ();

  stack_slider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    bus.step_tick = 1'b1;
    repeat (n) cyc();
    bus.step_tick = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset                   = 1'b0;
    bus.start               = 1'b0;
    bus.step_tick           = 1'b0;
    bus.drop                = 1'b0;
    bus.drop_ack            = 1'b0;
    bus.drop_hit            = 1'b0;
    bus.colour_in           = 3'd0;
    bus.colour_erase_enable = 1'b0;

    repeat (2) cyc();
    chk("rst_x", bus.x, 0);
    chk("rst_y", bus.y, 116);
    chk("rst_dir", bus.dir, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_drop_valid", bus.drop_valid, 0);
    chk("rst_drop_x", bus.drop_x, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_win", bus.win, 0);

    reset = 1'b1;
    ticks(8);
    chk("idle_no_move", bus.x, 0);

    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    ticks(7);
    chk("first_move_pending", bus.x, 0);
    ticks(1);
    chk("first_move_x", bus.x, 4);
    chk("first_move_dir", bus.dir, 1);

    ticks(38 * 8);
    chk("right_edge_x", bus.x, 156);
    chk("right_edge_dir", bus.dir, 1);
    ticks(8);
    chk("bounce_right_x", bus.x, 152);
    chk("bounce_right_dir", bus.dir, 0);
    ticks(38 * 8);
    chk("left_edge_x", bus.x, 0);
    chk("left_edge_dir", bus.dir, 0);
    ticks(8);
    chk("bounce_left_x", bus.x, 4);
    chk("bounce_left_dir", bus.dir, 1);

    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("start_ignored_move", bus.x, 4);
    bus.drop_ack = 1'b1; bus.drop_hit = 1'b1; cyc();
    bus.drop_ack = 1'b0; bus.drop_hit = 1'b0;
    chk("ack_ignored_move", bus.level, 0);

    ticks(9 * 8);
    chk("reach_40", bus.x, 40);
    ticks(7);
    bus.step_tick = 1'b1; bus.drop = 1'b1; cyc();
    bus.step_tick = 1'b0; bus.drop = 1'b0;
    chk("drop_valid", bus.drop_valid, 1);
    chk("drop_x", bus.drop_x, 40);
    chk("drop_outranks_move", bus.x, 40);

    bus.drop = 1'b1; ticks(20); bus.drop = 1'b0;
    chk("hold_x", bus.x, 40);
    chk("hold_valid", bus.drop_valid, 1);
    chk("hold_drop_x", bus.drop_x, 40);

    bus.drop_ack = 1'b1; bus.drop_hit = 1'b1; cyc();
    bus.drop_ack = 1'b0; bus.drop_hit = 1'b0;
    chk("hit_y", bus.y, 112);
    chk("hit_level", bus.level, 1);
    chk("hit_x", bus.x, 0);
    chk("hit_dir", bus.dir, 1);
    chk("hit_valid_clr", bus.drop_valid, 0);
    ticks(7);
`ifdef SLIDER_SPEEDUP_EN
    chk("lvl1_after7", bus.x, 4);
`else
    chk("lvl1_after7", bus.x, 0);
    ticks(1);
    chk("lvl1_after8", bus.x, 4);
`endif

    bus.drop = 1'b1; cyc(); bus.drop = 1'b0;
    bus.drop_ack = 1'b1; bus.drop_hit = 1'b0; cyc();
    bus.drop_ack = 1'b0;
    chk("miss_game_over", bus.game_over, 1);
    chk("miss_valid_clr", bus.drop_valid, 0);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("restart_game_over", bus.game_over, 0);
    chk("restart_y", bus.y, 116);
    chk("restart_level", bus.level, 0);
    chk("restart_x", bus.x, 0);

    for (int i = 0; i < 30; i++) begin
      bus.drop = 1'b1; cyc(); bus.drop = 1'b0;
      chk("climb_drop_valid", bus.drop_valid, 1);
      bus.drop_ack = 1'b1; bus.drop_hit = 1'b1; cyc();
      bus.drop_ack = 1'b0; bus.drop_hit = 1'b0;
      if (i < 29) chk("climb_level", bus.level, 32'(i + 1));
    end
    chk("win_flag", bus.win, 1);
    chk("win_y", bus.y, 0);
    chk("win_level", bus.level, 29);
    chk("win_valid_clr", bus.drop_valid, 0);
    chk("win_no_game_over", bus.game_over, 0);

    bus.colour_in = 3'd5; bus.colour_erase_enable = 1'b1; #1;
    chk("colour_erase", bus.colour, 0);
    bus.colour_erase_enable = 1'b0; #1;
    chk("colour_pass", bus.colour, 5);

    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("win_restart", bus.win, 0);
    ticks(16);
    chk("win_restart_x", bus.x, 8);
    bus.drop = 1'b1; cyc(); bus.drop = 1'b0;
    chk("pre_reset_valid", bus.drop_valid, 1);
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("reset_hold_valid", bus.drop_valid, 0);
    chk("reset_hold_x", bus.x, 0);
    chk("reset_hold_drop_x", bus.drop_x, 0);
    ticks(8);
    chk("reset_idle_x", bus.x, 0);
    bus.drop = 1'b1; cyc(); bus.drop = 1'b0;
    chk("reset_idle_drop", bus.drop_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
